// File: rtl/player_move_control_pkg.sv
// Shared maze definitions: geometry, cell codes, controller state encoding and
// the one-hot direction record.
package player_move_control_pkg;

    localparam int unsigned MAZE_DIM = 24;
    localparam int unsigned COORD_W  = 5;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned CELL_W   = 3;
    localparam int unsigned MOVES_W  = 7;

    localparam logic [COORD_W-1:0] TOP    = COORD_W'(0);
    localparam logic [COORD_W-1:0] LEFT   = COORD_W'(0);
    localparam logic [COORD_W-1:0] RIGHT  = COORD_W'(MAZE_DIM - 1);
    localparam logic [COORD_W-1:0] BOTTOM = COORD_W'(MAZE_DIM - 1);

    typedef enum logic [CELL_W-1:0] {
        OCCUPIED      = 3'd0,
        AVAILABLE     = 3'd1,
        START         = 3'd2,
        END           = 3'd3,
        YOUR_POSITION = 3'd4,
        PLUS_FIVE     = 3'd5,
        MINUS_FIVE    = 3'd6
    } cell_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_READ_WAIT,
        ST_REQUEST,
        ST_WAIT_VERDICT,
        ST_COMMIT,
        ST_DRAW_OLD,
        ST_DRAW_NEW,
        ST_CLEAR,
        ST_HALT
    } state_e;

    typedef struct packed {
        logic left;
        logic right;
        logic up;
        logic down;
    } dir_t;

endpackage

// File: rtl/player_move_control_if.sv
// Signal bundle between the move controller and its neighbours (keyboard
// decoder, maze memory, legality checker, redraw engine).
interface player_move_control_if;
    import player_move_control_pkg::*;

    logic moveLeft, moveRight, moveUp, moveDown;
    logic [CELL_W-1:0] memData;
    logic doneCheckLegal, isLegal, gameWon, gameOver, drawDone;

    logic [ADDR_W-1:0]  memAddress;
    logic [CELL_W-1:0]  valueInMemory;
    logic [COORD_W-1:0] x, y;
    logic dirLeft, dirRight, dirUp, dirDown;
    logic doneChangePosition;
    logic drawRequest;
    logic [COORD_W-1:0] drawX, drawY;
    logic [CELL_W-1:0]  drawValue;
    logic [MOVES_W-1:0] movesLeft;
    logic noMoreMoves;
    logic verdictTimeout;

    modport master (
        input  moveLeft, moveRight, moveUp, moveDown, memData,
               doneCheckLegal, isLegal, gameWon, gameOver, drawDone,
        output memAddress, valueInMemory, x, y,
               dirLeft, dirRight, dirUp, dirDown, doneChangePosition,
               drawRequest, drawX, drawY, drawValue,
               movesLeft, noMoreMoves, verdictTimeout
    );

    modport slave (
        output moveLeft, moveRight, moveUp, moveDown, memData,
               doneCheckLegal, isLegal, gameWon, gameOver, drawDone,
        input  memAddress, valueInMemory, x, y,
               dirLeft, dirRight, dirUp, dirDown, doneChangePosition,
               drawRequest, drawX, drawY, drawValue,
               movesLeft, noMoreMoves, verdictTimeout
    );

endinterface

// File: rtl/maze_addr_calc.sv
// Combinational neighbour-cell and memory-address computation; stops at the
// maze edges instead of wrapping.
module maze_addr_calc
    import player_move_control_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  dir_t               dir,
    output logic [COORD_W-1:0] tgt_x,
    output logic [COORD_W-1:0] tgt_y,
    output logic [ADDR_W-1:0]  addr
);

    always_comb begin
        tgt_x = x;
        tgt_y = y;
        if (dir.left && (x != LEFT)) begin
            tgt_x = x - COORD_W'(1);
        end else if (dir.right && (x != RIGHT)) begin
            tgt_x = x + COORD_W'(1);
        end
        if (dir.up && (y != TOP)) begin
            tgt_y = y - COORD_W'(1);
        end else if (dir.down && (y != BOTTOM)) begin
            tgt_y = y + COORD_W'(1);
        end
        addr = ADDR_W'(tgt_y) * ADDR_W'(MAZE_DIM) + ADDR_W'(tgt_x);
    end

endmodule

// File: rtl/player_move_control.sv
// Player move controller: turns move pulses into a memory read and a legality
// check request, then commits/discards the move and sequences the redraws.
module player_move_control
    import player_move_control_pkg::*;
#(
    parameter int unsigned START_X         = 1,
    parameter int unsigned START_Y         = 0,
    parameter int unsigned MAX_MOVES       = 99,
    parameter int unsigned MEM_LATENCY     = 2,
    parameter int unsigned VERDICT_TIMEOUT = 15
) (
    input logic clock,
    input logic reset,
    player_move_control_if.master bus
);

    localparam int unsigned CNT_W         = 5;
    localparam int unsigned VERDICT_GUARD = 2;

    state_e             state, state_nxt;
    logic [COORD_W-1:0] pos_x, pos_x_nxt, pos_y, pos_y_nxt;
    logic [COORD_W-1:0] tgt_x, tgt_y, calc_tgt_x, calc_tgt_y;
    dir_t               dir, dir_nxt, req;
    logic [ADDR_W-1:0]  mem_address, mem_addr_nxt, calc_addr;
    logic [CELL_W-1:0]  value, value_nxt;
    logic               done, done_nxt;
    logic               draw_req, draw_req_nxt;
    logic [COORD_W-1:0] draw_x, draw_x_nxt, draw_y, draw_y_nxt;
    cell_e              draw_val, draw_val_nxt;
    logic [MOVES_W-1:0] moves_left, moves_nxt;
    logic               timeout, timeout_nxt;
    logic [CNT_W-1:0]   rd_cnt, rd_cnt_nxt, wait_cnt, wait_cnt_nxt;
    logic               one_req, no_more, halt_req;

    assign req      = '{left: bus.moveLeft, right: bus.moveRight,
                        up: bus.moveUp, down: bus.moveDown};
    assign one_req  = $onehot(req);
    assign no_more  = (moves_left == '0);
    assign halt_req = (state != ST_IDLE) && (state != ST_HALT) && (bus.gameOver || bus.gameWon);

    // Target of the next-cycle position/direction; registering it keeps the
    // address and the commit target aligned with the latched direction.
    maze_addr_calc u_addr_calc (
        .x     (pos_x_nxt),
        .y     (pos_y_nxt),
        .dir   (dir_nxt),
        .tgt_x (calc_tgt_x),
        .tgt_y (calc_tgt_y),
        .addr  (calc_addr)
    );

    assign mem_addr_nxt = (state_nxt == ST_HALT) ? mem_address : calc_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            pos_x       <= COORD_W'(START_X);
            pos_y       <= COORD_W'(START_Y);
            tgt_x       <= COORD_W'(START_X);
            tgt_y       <= COORD_W'(START_Y);
            dir         <= '0;
            mem_address <= ADDR_W'(START_Y * MAZE_DIM + START_X);
            value       <= '0;
            done        <= 1'b0;
            draw_req    <= 1'b0;
            draw_x      <= '0;
            draw_y      <= '0;
            draw_val    <= OCCUPIED;
            moves_left  <= MOVES_W'(MAX_MOVES);
            timeout     <= 1'b0;
            rd_cnt      <= '0;
            wait_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            pos_x       <= pos_x_nxt;
            pos_y       <= pos_y_nxt;
            tgt_x       <= calc_tgt_x;
            tgt_y       <= calc_tgt_y;
            dir         <= dir_nxt;
            mem_address <= mem_addr_nxt;
            value       <= value_nxt;
            done        <= done_nxt;
            draw_req    <= draw_req_nxt;
            draw_x      <= draw_x_nxt;
            draw_y      <= draw_y_nxt;
            draw_val    <= draw_val_nxt;
            moves_left  <= moves_nxt;
            timeout     <= timeout_nxt;
            rd_cnt      <= rd_cnt_nxt;
            wait_cnt    <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pos_x_nxt    = pos_x;
        pos_y_nxt    = pos_y;
        dir_nxt      = dir;
        value_nxt    = value;
        done_nxt     = 1'b0;
        draw_req_nxt = draw_req;
        draw_x_nxt   = draw_x;
        draw_y_nxt   = draw_y;
        draw_val_nxt = draw_val;
        moves_nxt    = moves_left;
        timeout_nxt  = timeout;
        rd_cnt_nxt   = rd_cnt;
        wait_cnt_nxt = wait_cnt;

        unique case (state)
            ST_IDLE: begin
                if (one_req && !no_more) begin
                    dir_nxt    = req;
                    rd_cnt_nxt = '0;
                    state_nxt  = ST_READ_WAIT;
                end
            end
            ST_READ_WAIT: begin
                if (rd_cnt == CNT_W'(MEM_LATENCY - 1)) begin
                    value_nxt = bus.memData;
                    done_nxt  = 1'b1;
                    state_nxt = ST_REQUEST;
                end else begin
                    rd_cnt_nxt = rd_cnt + CNT_W'(1);
                end
            end
            ST_REQUEST: begin
                wait_cnt_nxt = '0;
                state_nxt    = ST_WAIT_VERDICT;
            end
            // First clocks may still see the previous verdict's level.
            ST_WAIT_VERDICT: begin
                if ((wait_cnt >= CNT_W'(VERDICT_GUARD)) && bus.doneCheckLegal) begin
                    state_nxt = bus.isLegal ? ST_COMMIT : ST_CLEAR;
                end else if (wait_cnt == CNT_W'(VERDICT_TIMEOUT - 1)) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = ST_CLEAR;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                pos_x_nxt    = tgt_x;
                pos_y_nxt    = tgt_y;
                draw_req_nxt = 1'b1;
                draw_x_nxt   = pos_x;
                draw_y_nxt   = pos_y;
                draw_val_nxt = AVAILABLE;
                if (moves_left != '0) begin
                    moves_nxt = moves_left - MOVES_W'(1);
                end
                state_nxt    = ST_DRAW_OLD;
            end
            ST_DRAW_OLD: begin
                if (bus.drawDone && draw_req) begin
                    draw_x_nxt   = pos_x;
                    draw_y_nxt   = pos_y;
                    draw_val_nxt = YOUR_POSITION;
                    state_nxt    = ST_DRAW_NEW;
                end
            end
            ST_DRAW_NEW: begin
                if (bus.drawDone && draw_req) begin
                    draw_req_nxt = 1'b0;
                    state_nxt    = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                dir_nxt      = '0;
                draw_req_nxt = 1'b0;
                state_nxt    = ST_IDLE;
            end
            ST_HALT: begin
                dir_nxt = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Terminal flags win over everything, including a same-clock verdict.
        if (halt_req) begin
            state_nxt    = ST_HALT;
            pos_x_nxt    = pos_x;
            pos_y_nxt    = pos_y;
            dir_nxt      = '0;
            value_nxt    = value;
            done_nxt     = 1'b0;
            draw_req_nxt = draw_req;
            draw_x_nxt   = draw_x;
            draw_y_nxt   = draw_y;
            draw_val_nxt = draw_val;
            moves_nxt    = moves_left;
            timeout_nxt  = timeout;
        end
    end

    assign bus.memAddress         = mem_address;
    assign bus.valueInMemory      = value;
    assign bus.x                  = pos_x;
    assign bus.y                  = pos_y;
    assign bus.dirLeft            = dir.left;
    assign bus.dirRight           = dir.right;
    assign bus.dirUp              = dir.up;
    assign bus.dirDown            = dir.down;
    assign bus.doneChangePosition = done;
    assign bus.drawRequest        = draw_req;
    assign bus.drawX              = draw_x;
    assign bus.drawY              = draw_y;
    assign bus.drawValue          = draw_val;
    assign bus.movesLeft          = moves_left;
    assign bus.noMoreMoves        = no_more;
    assign bus.verdictTimeout     = timeout;

endmodule

// File: tb/tb_player_move_control.sv
// Self-checking bench for player_move_control: directed table, corner-case
// sequences and a randomized walk checked against a position/move-count model.
module tb_player_move_control;

    logic clk;
    logic rst;
    player_move_control_if bus ();

    player_move_control dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Maze memory: data reflects the address of the previous clock.
    logic [2:0] maze [0:575];
    always @(posedge clk) bus.memData <= maze[bus.memAddress];

    int errors = 0;
    int checks = 0;
    int ex, ey, em;
    int last_addr;

    typedef struct {
        int d; bit legal; int addr; int x; int y; int moves;
    } vec_t;
    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v);
        return (v < 0) ? 0 : ((v > 23) ? 23 : v);
    endfunction

    function automatic int onehot(input int d);
        logic [3:0] v;
        v = 4'b1000;
        return int'(v >> d);
    endfunction

    function automatic int dirs();
        return int'({bus.dirLeft, bus.dirRight, bus.dirUp, bus.dirDown});
    endfunction

    task automatic clear_inputs();
        bus.moveLeft = 0; bus.moveRight = 0; bus.moveUp = 0; bus.moveDown = 0;
        bus.doneCheckLegal = 0; bus.isLegal = 0; bus.gameWon = 0; bus.gameOver = 0;
        bus.drawDone = 0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        ex = 1; ey = 0; em = 99;
    endtask

    task automatic pulse(input int d);
        bus.moveLeft = (d == 0); bus.moveRight = (d == 1);
        bus.moveUp = (d == 2); bus.moveDown = (d == 3);
        tick();
        bus.moveLeft = 0; bus.moveRight = 0; bus.moveUp = 0; bus.moveDown = 0;
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.doneChangePosition || (dirs() != 0)) hits++;
            tick();
        end
        chk(name, hits, 0);
    endtask

    // One full move transaction; the model position/moves update on legal verdicts.
    task automatic run_move(input int d, input bit legal, input int vdelay,
                            input int stall, input bit noise);
        int tx, ty, n;
        tx = clampi(ex + int'(d == 1) - int'(d == 0));
        ty = clampi(ey + int'(d == 3) - int'(d == 2));
        pulse(d);
        last_addr = int'(bus.memAddress);
        chk("read_addr", last_addr, ty * 24 + tx);
        chk("dir_latch", dirs(), onehot(d));
        n = 1;
        while (!bus.doneChangePosition && n < 10) begin tick(); n++; end
        chk("req_latency", n, 3);
        chk("value_in_mem", int'(bus.valueInMemory), int'(maze[ty * 24 + tx]));
        tick();
        if (noise) begin
            bus.moveDown = 1; tick(); bus.moveDown = 0;
            repeat (vdelay - 1) tick();
        end else begin
            repeat (vdelay) tick();
        end
        chk("dir_hold", dirs(), onehot(d));
        bus.doneCheckLegal = 1; bus.isLegal = legal;
        tick();
        bus.doneCheckLegal = 0; bus.isLegal = 0;
        if (legal) begin
            tick();
            chk("old_req", int'(bus.drawRequest), 1);
            chk("old_x", int'(bus.drawX), ex);
            chk("old_y", int'(bus.drawY), ey);
            chk("old_val", int'(bus.drawValue), 1);
            repeat (stall) tick();
            bus.drawDone = 1; tick(); bus.drawDone = 0;
            chk("new_req", int'(bus.drawRequest), 1);
            chk("new_x", int'(bus.drawX), tx);
            chk("new_y", int'(bus.drawY), ty);
            chk("new_val", int'(bus.drawValue), 4);
            repeat (stall) tick();
            bus.drawDone = 1; tick(); bus.drawDone = 0;
            chk("draw_release", int'(bus.drawRequest), 0);
            ex = tx; ey = ty;
            if (em > 0) em--;
        end else begin
            chk("illegal_no_draw", int'(bus.drawRequest), 0);
        end
        tick();
        chk("pos_x", int'(bus.x), ex);
        chk("pos_y", int'(bus.y), ey);
        chk("moves_left", int'(bus.movesLeft), em);
        chk("no_more", int'(bus.noMoreMoves), int'(em == 0));
        chk("dir_cleared", dirs(), 0);
        chk("idle_addr", int'(bus.memAddress), ey * 24 + ex);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, guard;
        rst = 0;
        clear_inputs();
        for (int i = 0; i < 576; i++) maze[i] = 3'($urandom_range(0, 6));

        tbl[0] = '{1, 1'b1,  2, 2, 0, 98};
        tbl[1] = '{2, 1'b1,  2, 2, 0, 97};
        tbl[2] = '{3, 1'b1, 26, 2, 1, 96};
        tbl[3] = '{0, 1'b0, 25, 2, 1, 96};
        tbl[4] = '{0, 1'b1, 25, 1, 1, 95};
        tbl[5] = '{3, 1'b0, 49, 1, 1, 95};
        tbl[6] = '{0, 1'b1, 24, 0, 1, 94};
        tbl[7] = '{0, 1'b1, 24, 0, 1, 93};

        // Reset state
        reset_dut();
        chk("rst_x", int'(bus.x), 1);
        chk("rst_y", int'(bus.y), 0);
        chk("rst_moves", int'(bus.movesLeft), 99);
        chk("rst_addr", int'(bus.memAddress), 1);
        chk("rst_done", int'(bus.doneChangePosition), 0);
        chk("rst_req", int'(bus.drawRequest), 0);
        chk("rst_dirs", dirs(), 0);
        chk("rst_timeout", int'(bus.verdictTimeout), 0);
        chk("rst_value", int'(bus.valueInMemory), 0);
        chk("rst_no_more", int'(bus.noMoreMoves), 0);
        chk("rst_draw", int'({bus.drawX, bus.drawY, bus.drawValue}), 0);

        // Directed table from the start cell
        for (int i = 0; i < 8; i++) begin
            run_move(tbl[i].d, tbl[i].legal, 2 + i, i % 3, 1'b0);
            chk("tbl_addr", last_addr, tbl[i].addr);
            chk("tbl_x", int'(bus.x), tbl[i].x);
            chk("tbl_y", int'(bus.y), tbl[i].y);
            chk("tbl_moves", int'(bus.movesLeft), tbl[i].moves);
        end

        // Left edge: target stays on the current cell
        reset_dut();
        run_move(0, 1'b1, 2, 0, 1'b0);
        for (int i = 0; i < 5; i++) run_move(3, 1'b1, 2, 0, 1'b0);
        run_move(0, 1'b0, 3, 0, 1'b0);
        chk("edge_addr", last_addr, 120);
        chk("edge_x", int'(bus.x), 0);
        chk("edge_moves", int'(bus.movesLeft), 93);

        // Two simultaneous pulses are ignored
        bus.moveUp = 1; bus.moveLeft = 1;
        tick();
        bus.moveUp = 0; bus.moveLeft = 0;
        expect_quiet("double_pulse", 6);
        chk("double_addr", int'(bus.memAddress), 120);

        // A pulse during the verdict wait is dropped, not queued
        run_move(1, 1'b0, 4, 0, 1'b1);
        expect_quiet("dropped_pulse", 6);

        // Stale verdict level across request and guard clocks, then timeout
        pulse(1);
        n = 1;
        while (!bus.doneChangePosition && n < 10) begin tick(); n++; end
        chk("stale_latency", n, 3);
        bus.doneCheckLegal = 1; bus.isLegal = 1;
        repeat (3) tick();
        bus.doneCheckLegal = 0; bus.isLegal = 0;
        repeat (12) tick();
        chk("timeout_early", int'(bus.verdictTimeout), 0);
        chk("stale_no_draw", int'(bus.drawRequest), 0);
        tick();
        chk("timeout_set", int'(bus.verdictTimeout), 1);
        tick();
        chk("timeout_x", int'(bus.x), ex);
        chk("timeout_moves", int'(bus.movesLeft), em);
        chk("timeout_dirs", dirs(), 0);
        repeat (3) tick();
        chk("timeout_sticky", int'(bus.verdictTimeout), 1);

        // Randomized walk down to the last move
        reset_dut();
        guard = 0;
        while (em > 1 && guard < 400) begin
            run_move(int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                     int'($urandom_range(2, 12)), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) == 0));
            guard++;
        end
        chk("walk_moves", int'(bus.movesLeft), 1);
        run_move(1, 1'b1, 2, 0, 1'b0);
        chk("last_move_zero", int'(bus.movesLeft), 0);
        chk("last_no_more", int'(bus.noMoreMoves), 1);
        pulse(1);
        expect_quiet("no_moves_left", 6);
        chk("exhausted_x", int'(bus.x), ex);

        // gameOver while drawing the old cell freezes everything
        reset_dut();
        pulse(1);
        n = 1;
        while (!bus.doneChangePosition && n < 10) begin tick(); n++; end
        repeat (3) tick();
        bus.doneCheckLegal = 1; bus.isLegal = 1;
        tick();
        bus.doneCheckLegal = 0; bus.isLegal = 0;
        tick();
        chk("halt_pre_req", int'(bus.drawRequest), 1);
        bus.gameOver = 1;
        tick();
        bus.gameOver = 0;
        chk("halt_x", int'(bus.x), 2);
        chk("halt_moves", int'(bus.movesLeft), 98);
        chk("halt_dirs", dirs(), 0);
        bus.drawDone = 1; bus.moveLeft = 1;
        tick();
        bus.drawDone = 0; bus.moveLeft = 0;
        expect_quiet("halt_quiet", 4);
        chk("halt_req", int'(bus.drawRequest), 1);
        chk("halt_draw_x", int'(bus.drawX), 1);
        chk("halt_draw_y", int'(bus.drawY), 0);
        chk("halt_draw_val", int'(bus.drawValue), 1);
        chk("halt_x_frozen", int'(bus.x), 2);
        reset_dut();
        chk("post_halt_x", int'(bus.x), 1);
        chk("post_halt_y", int'(bus.y), 0);
        chk("post_halt_moves", int'(bus.movesLeft), 99);
        chk("post_halt_req", int'(bus.drawRequest), 0);
        run_move(3, 1'b1, 2, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
